// File: rtl/button_pkg.sv
// Shared encodings and default timing constants for the button event path.
package button_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_LONG    = 2'd1,
        EVT_REPEAT  = 2'd2,
        EVT_RELEASE = 2'd3
    } evt_kind_t;

    typedef enum logic [1:0] {
        BTN_IDLE    = 2'd0,
        BTN_PRESSED = 2'd1,
        BTN_HELD    = 2'd2
    } btn_fsm_t;

    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

endpackage

// File: rtl/btn_hold_timer.sv
// One button's IDLE/PRESSED/HELD tracker; emits PRESS, LONG, REPEAT and RELEASE
// combinationally in the cycle the condition occurs.
module btn_hold_timer
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = 27
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      state_i,
    input  logic      down_i,
    input  logic      up_i,
    input  logic      repeat_en_i,
    output logic      emit_o,
    output evt_kind_t kind_o
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    btn_fsm_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BTN_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        emit_o  = 1'b0;
        kind_o  = EVT_PRESS;
        if (down_i) begin
            state_d = BTN_PRESSED;
            cnt_d   = '0;
            emit_o  = 1'b1;
        end else if (up_i) begin
            // An idle button (e.g. one held through reset) never saw its PRESS,
            // so its release stays silent.
            state_d = BTN_IDLE;
            cnt_d   = '0;
            emit_o  = (state_q != BTN_IDLE);
            kind_o  = EVT_RELEASE;
        end else if (state_q != BTN_IDLE && !state_i) begin
            state_d = BTN_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                BTN_PRESSED: begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = BTN_HELD;
                        cnt_d   = '0;
                        emit_o  = 1'b1;
                        kind_o  = EVT_LONG;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                BTN_HELD: begin
                    if (cnt_q == REP_LAST) begin
                        cnt_d  = '0;
                        emit_o = repeat_en_i;
                        kind_o = EVT_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Per-button hold timers feeding one-entry event slots, round-robin arbitrated
// onto a single registered valid/ready event stream.
module button_event_arbiter
    import button_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = 27,
    parameter int ID_W          = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_state,
    input  logic [N_BTN-1:0] btn_down,
    input  logic [N_BTN-1:0] btn_up,
    input  logic             repeat_en,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic [1:0]       evt_kind,
    output logic             evt_dropped,
    output logic [N_BTN-1:0] pending
);

    logic [N_BTN-1:0] emit;
    evt_kind_t        emit_kind [N_BTN];

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_hold_timer #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_W         (CNT_W)
        ) u_timer (
            .clk         (clk),
            .rst         (rst),
            .state_i     (btn_state[g]),
            .down_i      (btn_down[g]),
            .up_i        (btn_up[g]),
            .repeat_en_i (repeat_en),
            .emit_o      (emit[g]),
            .kind_o      (emit_kind[g])
        );
    end

    logic [N_BTN-1:0] slot_v_q, slot_v_d;
    evt_kind_t        slot_k_q [N_BTN];
    evt_kind_t        slot_k_d [N_BTN];
    logic             evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]  evt_id_q, evt_id_d;
    evt_kind_t        evt_kind_q, evt_kind_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             dropped_q, dropped_d;

    logic             load, found, take;
    logic [ID_W-1:0]  win;

    always_comb begin : arb
        int j;
        load  = !evt_valid_q || evt_ready;
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < N_BTN; k++) begin
            j = (int'(ptr_q) + k) % N_BTN;
            if (!found && slot_v_q[j]) begin
                found = 1'b1;
                win   = ID_W'(j);
            end
        end
        take = load && found;
    end

    // A slot drained this cycle is free for a new event; a queued REPEAT is
    // superseded by newer events, anything else is kept and the newcomer dropped.
    always_comb begin
        slot_v_d  = slot_v_q;
        slot_k_d  = slot_k_q;
        dropped_d = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (take && int'(win) == i) slot_v_d[i] = 1'b0;
            if (emit[i]) begin
                if (!slot_v_d[i]) begin
                    slot_v_d[i] = 1'b1;
                    slot_k_d[i] = emit_kind[i];
                end else begin
                    dropped_d = 1'b1;
                    if (slot_k_q[i] == EVT_REPEAT) slot_k_d[i] = emit_kind[i];
                end
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_kind_d  = evt_kind_q;
        ptr_d       = ptr_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_id_d   = win;
                evt_kind_d = slot_k_q[win];
                ptr_d      = (int'(win) == N_BTN - 1) ? '0 : win + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_kind_q  <= EVT_PRESS;
            ptr_q       <= '0;
            dropped_q   <= 1'b0;
        end else begin
            slot_v_q    <= slot_v_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_kind_q  <= evt_kind_d;
            ptr_q       <= ptr_d;
            dropped_q   <= dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_k_q <= slot_k_d;
    end

    assign evt_valid   = evt_valid_q;
    assign evt_id      = evt_id_q;
    assign evt_kind    = evt_kind_q;
    assign evt_dropped = dropped_q;
    assign pending     = slot_v_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Randomized + directed bench for button_event_arbiter with an age-based
// reference model and a queue scoreboard checked at each handshake.
module tb_button_event_arbiter;

    localparam int N = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_state = '0;
    logic [N-1:0] btn_down = '0;
    logic [N-1:0] btn_up = '0;
    logic         repeat_en = 1'b1;
    logic         evt_ready = 1'b1;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [1:0]   evt_kind;
    logic         evt_dropped;
    logic [N-1:0] pending;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN(N), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(27), .ID_W(2)
    ) dut (
        .clk(clk), .rst(rst), .btn_state(btn_state), .btn_down(btn_down),
        .btn_up(btn_up), .repeat_en(repeat_en), .evt_ready(evt_ready),
        .evt_valid(evt_valid), .evt_id(evt_id), .evt_kind(evt_kind),
        .evt_dropped(evt_dropped), .pending(pending)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: button activity tracked as age since PRESS.
    bit m_act [N];
    int m_age [N];
    bit m_ev  [N];
    int m_ek  [N];
    bit s_v   [N];
    int s_k   [N];
    bit o_v = 1'b0;
    int ptr = 0;

    typedef struct packed {
        logic         r;
        logic         v;
        logic         d;
        logic [N-1:0] p;
    } cyc_t;

    cyc_t cyc_q[$];
    int   ev_q[$];

    always @(posedge clk) begin : model
        cyc_t c;
        bit   drop;
        bit   load;
        int   w;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] = 1'b0;
                m_age[i] = 0;
                s_v[i]   = 1'b0;
            end
            o_v = 1'b0;
            ptr = 0;
            ev_q.delete();
            c = '{r: 1'b1, v: 1'b0, d: 1'b0, p: '0};
        end else begin
            for (int i = 0; i < N; i++) begin
                m_ev[i] = 1'b0;
                m_ek[i] = 0;
                if (btn_down[i]) begin
                    m_ev[i] = 1'b1; m_ek[i] = 0; m_act[i] = 1'b1; m_age[i] = 0;
                end else if (btn_up[i]) begin
                    if (m_act[i]) begin m_ev[i] = 1'b1; m_ek[i] = 3; end
                    m_act[i] = 1'b0;
                end else if (m_act[i] && !btn_state[i]) begin
                    m_act[i] = 1'b0;
                end else if (m_act[i]) begin
                    m_age[i]++;
                    if (m_age[i] == L) begin
                        m_ev[i] = 1'b1; m_ek[i] = 1;
                    end else if (m_age[i] > L && (m_age[i] - L) % R == 0 && repeat_en) begin
                        m_ev[i] = 1'b1; m_ek[i] = 2;
                    end
                end
            end
            load = !o_v || evt_ready;
            w = -1;
            if (load) begin
                for (int k = 0; k < N; k++)
                    if (w < 0 && s_v[(ptr + k) % N]) w = (ptr + k) % N;
                if (w >= 0) begin
                    o_v = 1'b1;
                    ev_q.push_back(w * 4 + s_k[w]);
                    s_v[w] = 1'b0;
                    ptr = (w + 1) % N;
                end else begin
                    o_v = 1'b0;
                end
            end
            drop = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (m_ev[i]) begin
                    if (!s_v[i]) begin
                        s_v[i] = 1'b1; s_k[i] = m_ek[i];
                    end else begin
                        drop = 1'b1;
                        if (s_k[i] == 2) s_k[i] = m_ek[i];
                    end
                end
            end
            c.r = 1'b0;
            c.v = o_v;
            c.d = drop;
            for (int i = 0; i < N; i++) c.p[i] = s_v[i];
        end
        cyc_q.push_back(c);
    end

    bit         hold_prev = 1'b0;
    logic [1:0] id_prev, kind_prev;

    always @(negedge clk) begin : monitor
        cyc_t c;
        int   e;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("evt_valid", 32'(evt_valid), 32'(c.v));
            chk("evt_dropped", 32'(evt_dropped), 32'(c.d));
            chk("pending", 32'(pending), 32'(c.p));
            if (c.r) begin
                chk("reset_id", 32'(evt_id), 32'd0);
                chk("reset_kind", 32'(evt_kind), 32'd0);
            end
        end
        if (hold_prev) begin
            chk("stall_valid", 32'(evt_valid), 32'd1);
            chk("stall_id", 32'(evt_id), 32'(id_prev));
            chk("stall_kind", 32'(evt_kind), 32'(kind_prev));
        end
        hold_prev = (evt_valid === 1'b1) && (evt_ready === 1'b0) && (rst === 1'b0);
        id_prev   = evt_id;
        kind_prev = evt_kind;
        if (evt_valid === 1'b1 && evt_ready === 1'b1 && rst === 1'b0) begin
            if (ev_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got id=%0d kind=%0d expected none at %0t",
                         evt_id, evt_kind, $time);
            end else begin
                e = ev_q.pop_front();
                chk("evt_id", 32'(evt_id), 32'(e / 4));
                chk("evt_kind", 32'(evt_kind), 32'(e % 4));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        btn_down = '0;
        btn_up   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic press(input int i);
        btn_down[i]  = 1'b1;
        btn_state[i] = 1'b1;
        step();
    endtask

    task automatic rel(input int i);
        btn_up[i]    = 1'b1;
        btn_state[i] = 1'b0;
        step();
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        idle(6);

        // single press / release
        press(2); idle(4); rel(2); idle(8);

        // long hold with and without repeats
        repeat_en = 1'b1;
        press(0); idle(59); rel(0); idle(8);
        repeat_en = 1'b0;
        press(0); idle(59); rel(0); idle(8);
        repeat_en = 1'b1;

        // simultaneous bursts
        btn_down = 4'b1011; btn_state = 4'b1011; step(); idle(6);
        btn_up = 4'b1011; btn_state = 4'b0000; step(); idle(6);
        btn_down = 4'b1001; btn_state = 4'b1001; step(); idle(6);
        btn_up = 4'b1001; btn_state = 4'b0000; step(); idle(6);

        // backpressure during a long hold
        press(1); idle(2);
        evt_ready = 1'b0; idle(30);
        evt_ready = 1'b1; idle(25); rel(1); idle(8);

        // reset while held with a stalled output
        press(0); idle(2);
        evt_ready = 1'b0; idle(32);
        rst = 1'b1; step(); rst = 1'b0;
        evt_ready = 1'b1; idle(10);
        rel(0); idle(5);
        press(0); idle(5); rel(0); idle(5);

        // down and up in the same cycle
        btn_down[2] = 1'b1; btn_up[2] = 1'b1; btn_state[2] = 1'b1; step();
        idle(25); rel(2); idle(5);

        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!btn_state[i] && $urandom_range(0, 15) == 0) begin
                    btn_down[i] = 1'b1; btn_state[i] = 1'b1;
                end else if (btn_state[i] && $urandom_range(0, 39) == 0) begin
                    btn_up[i] = 1'b1; btn_state[i] = 1'b0;
                end else if (btn_state[i] && $urandom_range(0, 199) == 0) begin
                    btn_state[i] = 1'b0;
                end
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) repeat_en = ~repeat_en;
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;
        evt_ready = 1'b1;
        btn_state = '0;
        idle(40);
        chk("drained", 32'(ev_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
